// File: rtl/fetcher_pkg.sv
// Shared encodings for the fetch stage: scheduler states, fetcher states and the NOP word.
// Also holds the sizing helper for the fetch wait counter.
package fetcher_pkg;

  localparam logic [2:0] CORE_IDLE   = 3'b000;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    FETCHER_IDLE       = 3'b000,
    FETCHER_REQUESTING = 3'b001,
    FETCHER_FETCHED    = 3'b010
  } fetcher_state_t;

  localparam logic [15:0] NOP_INSTRUCTION = 16'h0000;

  // A disabled timeout (0) still needs a 1-bit counter so the declaration stays legal.
  function automatic int wait_counter_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/fetcher.sv
// Instruction fetch stage: requests the word at current_pc over valid/ready, holds it for decode,
// and substitutes a NOP plus fetch_error if the memory does not answer within TIMEOUT_CYCLES.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error
);

  localparam int CW = wait_counter_width(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PROGRAM_MEM_DATA_BITS-1:0] NOP_WORD = PROGRAM_MEM_DATA_BITS'(NOP_INSTRUCTION);

  fetcher_state_t                   state, state_next;
  logic [CW-1:0]                    wait_count, wait_count_next;
  logic                             valid_next;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] address_next;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_next;
  logic                             error_next;
  logic                             timed_out;

  // The counter stops at LAST_WAIT because that cycle always leaves REQUESTING, so it never wraps.
  assign timed_out     = TIMEOUT_EN && (wait_count == LAST_WAIT);
  assign fetcher_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FETCHER_IDLE;
      wait_count       <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      fetch_error      <= 1'b0;
    end else begin
      state            <= state_next;
      wait_count       <= wait_count_next;
      mem_read_valid   <= valid_next;
      mem_read_address <= address_next;
      instruction      <= instruction_next;
      fetch_error      <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCHER_IDLE:       if (core_state == CORE_FETCH) state_next = FETCHER_REQUESTING;
      FETCHER_REQUESTING: if (mem_read_ready || timed_out) state_next = FETCHER_FETCHED;
      FETCHER_FETCHED:    if (core_state == CORE_DECODE) state_next = FETCHER_IDLE;
      default:            state_next = FETCHER_IDLE;
    endcase
  end

  // Ready wins over timeout; core_state is ignored once a request is in flight.
  always_comb begin
    wait_count_next  = wait_count;
    valid_next       = mem_read_valid;
    address_next     = mem_read_address;
    instruction_next = instruction;
    error_next       = fetch_error;
    case (state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          valid_next      = 1'b1;
          address_next    = current_pc;
          wait_count_next = '0;
          error_next      = 1'b0;
        end
      end
      FETCHER_REQUESTING: begin
        if (mem_read_ready) begin
          instruction_next = mem_read_data;
          valid_next       = 1'b0;
        end else if (timed_out) begin
          instruction_next = NOP_WORD;
          error_next       = 1'b1;
          valid_next       = 1'b0;
        end else begin
          wait_count_next = wait_count + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule
